pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Programmable pulse-train generator. Turns a single-cycle start strobe into a registered waveform of N high pulses, each high for H cycles and separated by L low cycles.
- Counterpart to the edge detectors: those reduce a level to edge strobes; this block builds edges and levels from a command strobe.
- Used to drive enables, strobes and test stimulus that downstream edge detectors consume.

Parameters:
CNT_W, 16, width of the high/low phase length inputs and of the internal phase counter
NUM_W, 8, width of the pulse count input and of the remaining-pulse counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-low
start  input  1  single-cycle request; sampled only in IDLE
abort  input  1  terminate the current train
high_cyc  input  CNT_W  high phase length H in cycles; 0 treated as 1
low_cyc  input  CNT_W  low phase length L in cycles; 0 treated as 1
num_pulses  input  NUM_W  pulse count N; 0 means no train
wave_out  output  1  generated waveform, registered
busy  output  1  high while a train is in progress
done  output  1  one-cycle strobe on normal completion
pulses_left  output  NUM_W  pulses not yet started, including none for the current one

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; wave_out=0, busy=0, done=0, pulses_left=0; all counters cleared. Reset overrides every input, including mid-train. wave_out is 0 from the next edge with no done strobe.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, HIGH, LOW.
- Config latch: on an accepted start, high_cyc, low_cyc and num_pulses are captured into internal registers. Input changes during a train have no effect.
- IDLE, start=1, abort=0, N>0 (edge T):
  - Go to HIGH.
  - From T+1: wave_out=1, busy=1, pulses_left=N-1.
- IDLE, start=1, abort=0, N=0 (edge T):
  - Stay IDLE; no wave and busy stays 0.
  - done=1 for the single cycle T+1.
- IDLE, start=1, abort=1: abort wins; start is ignored, no done.
- HIGH:
  - wave_out stays high for exactly H cycles.
  - After H cycles, if pulses_left>0: go to LOW; wave_out=0 for exactly L cycles.
  - After H cycles, if pulses_left=0: go to IDLE. On that edge wave_out=0, busy=0 and done=1 for one cycle. The final low phase is not run.
- LOW:
  - After L cycles, go to HIGH.
  - pulses_left decrements on the same edge that wave_out rises.
- Total busy duration = N*H + (N-1)*L cycles. The first wave_out rise comes one cycle after the start edge.
- start while busy=1 is ignored; no queuing, no retrigger.
- abort=1 in HIGH or LOW:
  - On the next edge go to IDLE with wave_out=0, busy=0, pulses_left=0 and done=0.
  - A start in the cycle right after the abort edge is accepted normally.
- start on the same edge that done asserts is ignored, because the FSM was still busy. start is accepted from the following cycle.
- Counter widths:
  - The phase counter is CNT_W bits and counts down from H-1 or L-1 to 0. The maximum phase length is 2^CNT_W-1.
  - H=0 and L=0 are clamped to 1 at latch time.
  - No wrap-around is permitted. Counter compares are against 0, never via overflow.
- Every cycle wave_out changes level is exactly one phase boundary. There are no glitches and no zero-length phases.

Test Plan:
- Reset then start with H=3, L=2, N=3 -> wave_out reads 1110011100111 starting at T+1; busy high for 13 cycles; done=1 at cycle T+14 only; pulses_left shows 2,1,0 at each rise.
- H=0, L=0, N=2 -> wave_out 101 from T+1 (clamped to 1); busy for 3 cycles; done once.
- N=0 start -> wave_out and busy stay 0; done=1 at T+1 only.
- H=4, L=4, N=5 with abort on the 2nd high cycle of pulse 2 -> next edge wave_out=0, busy=0, pulses_left=0; no done; a new start 1 cycle later with H=1, L=1, N=1 gives a single 1-cycle pulse plus done.
- Start held high for the entire train, plus input changes mid-train -> only one train with the latched config; start asserted on the done edge is ignored, re-asserted next cycle begins a new train.
- rst=0 asserted mid-LOW phase of H=2, L=5, N=4 -> all outputs 0 next edge, no done; start with rst=0 is ignored; after release a normal train runs.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: a start strobe launches N pulses of H high / L low cycles.
// Latency: first wave_out rise one cycle after the start edge; all outputs registered.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cyc,
    input  logic [CNT_W-1:0] low_cyc,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             wave_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulses_left
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cfg_h, cfg_h_nxt;
    logic [CNT_W-1:0] cfg_l, cfg_l_nxt;
    logic [NUM_W-1:0] left_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] h_cl, l_cl;

    // Zero-length phases would glitch the waveform, so they are clamped to one cycle.
    assign h_cl = (high_cyc == '0) ? CNT_ONE : high_cyc;
    assign l_cl = (low_cyc  == '0) ? CNT_ONE : low_cyc;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cfg_h_nxt = cfg_h;
        cfg_l_nxt = cfg_l;
        left_nxt  = pulses_left;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    cfg_h_nxt = h_cl;
                    cfg_l_nxt = l_cl;
                    if (num_pulses != '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = h_cl - CNT_ONE;
                        left_nxt  = num_pulses - NUM_ONE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    left_nxt  = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (pulses_left != '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = cfg_l - CNT_ONE;
                end else begin
                    // Last pulse: the trailing low phase is skipped entirely.
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    left_nxt  = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = HIGH;
                    cnt_nxt   = cfg_h - CNT_ONE;
                    left_nxt  = pulses_left - NUM_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                left_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cfg_h       <= '0;
            cfg_l       <= '0;
            pulses_left <= '0;
            wave_out    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cfg_h       <= cfg_h_nxt;
            cfg_l       <= cfg_l_nxt;
            pulses_left <= left_nxt;
            wave_out    <= (state_nxt == HIGH);
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: each accepted start expands into the full expected
// per-cycle output train; a monitor pops and compares one entry after every clock edge.
module tb_pulse_train_gen;

    localparam int CNT_W = 4;
    localparam int NUM_W = 4;

    typedef struct packed {
        logic             wave;
        logic             busy;
        logic             done;
        logic [NUM_W-1:0] left;
    } out_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] high_cyc = '0;
    logic [CNT_W-1:0] low_cyc = '0;
    logic [NUM_W-1:0] num_pulses = '0;
    logic             wave_out;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulses_left;

    out_t plan[$];
    out_t exp_q[$];
    out_t cur = '0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;

    pulse_train_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .high_cyc(high_cyc), .low_cyc(low_cyc), .num_pulses(num_pulses),
        .wave_out(wave_out), .busy(busy), .done(done), .pulses_left(pulses_left)
    );

    always #5 clk = ~clk;

    // Whole-train model: an accepted start becomes a list of N*H + (N-1)*L busy cycles
    // followed by a single done cycle; idle cycles default to all zeros.
    task automatic model(input logic s, input logic a, input logic r,
                         input int h, input int l, input int n);
        out_t nxt;
        int   hh, ll;
        nxt = '0;
        if (!r) begin
            plan.delete();
        end else if (cur.busy && a) begin
            plan.delete();
        end else if (!cur.busy && s && !a) begin
            hh = (h == 0) ? 1 : h;
            ll = (l == 0) ? 1 : l;
            for (int p = 0; p < n; p++) begin
                for (int k = 0; k < hh; k++) plan.push_back('{1'b1, 1'b1, 1'b0, NUM_W'(n - 1 - p)});
                if (p != n - 1)
                    for (int k = 0; k < ll; k++) plan.push_back('{1'b0, 1'b1, 1'b0, NUM_W'(n - 1 - p)});
            end
            plan.push_back('{1'b0, 1'b0, 1'b1, NUM_W'(0)});
        end
        if (plan.size() > 0) nxt = plan.pop_front();
        cur = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic step(input logic s, input logic a, input logic r,
                        input int h, input int l, input int n);
        @(negedge clk);
        start      = s;
        abort      = a;
        rst        = r;
        high_cyc   = CNT_W'(h);
        low_cyc    = CNT_W'(l);
        num_pulses = NUM_W'(n);
        model(s, a, r, h, l, n);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    endtask

    initial begin : monitor
        out_t e, g;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{wave_out, busy, done, pulses_left};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs @cycle %0d: wave/busy/done/left got %b/%b/%b/%0d required %b/%b/%b/%0d",
                             cycle, g.wave, g.busy, g.done, g.left, e.wave, e.busy, e.done, e.left);
                end
            end
        end
    end

    initial begin : stimulus
        int h, l, n;
        logic s, a, r;

        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle(2);

        // Basic train, then clamped phases, then the empty train.
        step(1'b1, 1'b0, 1'b1, 3, 2, 3);
        idle(16);
        step(1'b1, 1'b0, 1'b1, 0, 0, 2);
        idle(5);
        step(1'b1, 1'b0, 1'b1, 5, 5, 0);
        idle(3);

        // Abort on the second high cycle of pulse 2, then an immediate restart.
        step(1'b1, 1'b0, 1'b1, 4, 4, 5);
        idle(9);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 1, 1, 1);
        idle(4);

        // start+abort together in IDLE is dropped.
        step(1'b1, 1'b1, 1'b1, 2, 2, 2);
        idle(3);

        // Start held across trains while the config inputs wander.
        step(1'b1, 1'b0, 1'b1, 2, 1, 2);
        for (int i = 0; i < 30; i++)
            step(1'b1, 1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 3));
        idle(20);

        // Reset during the low phase, start ignored while held in reset.
        step(1'b1, 1'b0, 1'b1, 2, 5, 4);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 2, 5, 4);
        step(1'b1, 1'b0, 1'b0, 2, 5, 4);
        step(1'b1, 1'b0, 1'b1, 2, 5, 4);
        idle(35);

        // Maximum phase lengths.
        step(1'b1, 1'b0, 1'b1, 15, 15, 2);
        idle(50);

        for (int i = 0; i < 2500; i++) begin
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 199) != 0);
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            step(s, a, r, h, l, n);
        end
        idle(2);
        @(posedge clk);
        #3;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
